fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 59 +++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch stage: PC register plus IF/ID pipeline register.
module fetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_SIZE   = 512,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [ADDR_WIDTH-1:0] inst_addr,
   input  logic [DATA_WIDTH-1:0] inst,
   output logic                  id_valid,
   output logic [ADDR_WIDTH-1:0] id_pc,
   output logic [ADDR_WIDTH-1:0] id_pc_plus4,
   output logic [DATA_WIDTH-1:0] id_inst,
   output logic                  id_fault
);

   localparam logic [DATA_WIDTH-1:0] NOP        = DATA_WIDTH'(32'h0000_0013);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
   // One extra bit so MEM_SIZE*4 cannot alias onto a small address.
   localparam logic [ADDR_WIDTH:0]   MEM_LIMIT  = (ADDR_WIDTH+1)'(MEM_SIZE * 4);

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_plus4;
   logic                  in_range;

   assign inst_addr = pc;
   assign pc_plus4  = pc + ADDR_WIDTH'(4);
   assign in_range  = ({1'b0, pc} < MEM_LIMIT);

   // Redirect outranks stall; a flush leaves id_pc/id_pc_plus4 untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         id_valid    <= 1'b0;
         id_pc       <= '0;
         id_pc_plus4 <= '0;
         id_inst     <= NOP;
         id_fault    <= 1'b0;
      end else if (redirect_valid) begin
         pc          <= redirect_pc & ALIGN_MASK;
         id_valid    <= 1'b0;
         id_inst     <= NOP;
         id_fault    <= 1'b0;
      end else if (!stall) begin
         pc          <= pc_plus4;
         id_valid    <= 1'b1;
         id_pc       <= pc;
         id_pc_plus4 <= pc_plus4;
         id_inst     <= in_range ? inst : NOP;
         id_fault    <= ~in_range;
      end
   end

endmodule
